// File: rtl/reservation_station.sv
// ============================================================================
//  Module      : reservation_station
//  Description : ALU reservation station. It buffers dispatched ops, wakes
//                their operands from the ALU and load CDBs, and issues one
//                ready op per cycle.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module reservation_station #(
   parameter int RS_SIZE    = 8,
   parameter int ID_WIDTH   = 32,
   parameter int ROB_WIDTH  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int OP_WIDTH   = 6
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  rob_rs_clear_in,
   input  logic                  dispatcher_rs_en_in,
   input  logic [ID_WIDTH-1:0]   dispatcher_rs_a_in,
   input  logic [ID_WIDTH-1:0]   dispatcher_rs_vj_in,
   input  logic [ID_WIDTH-1:0]   dispatcher_rs_vk_in,
   input  logic [ROB_WIDTH-1:0]  dispatcher_rs_qj_in,
   input  logic [ROB_WIDTH-1:0]  dispatcher_rs_qk_in,
   input  logic [ROB_WIDTH-1:0]  dispatcher_rs_dest_in,
   input  logic [ADDR_WIDTH-1:0] dispatcher_rs_pc_in,
   input  logic [OP_WIDTH-1:0]   dispatcher_rs_opcode_in,
   input  logic                  alu_cdb_en_in,
   input  logic [ROB_WIDTH-1:0]  alu_cdb_tag_in,
   input  logic [ID_WIDTH-1:0]   alu_cdb_value_in,
   input  logic                  lsb_cdb_en_in,
   input  logic [ROB_WIDTH-1:0]  lsb_cdb_tag_in,
   input  logic [ID_WIDTH-1:0]   lsb_cdb_value_in,
   output logic                  rs_full_out,
   output logic                  rs_alu_en_out,
   output logic [ID_WIDTH-1:0]   rs_alu_vj_out,
   output logic [ID_WIDTH-1:0]   rs_alu_vk_out,
   output logic [ID_WIDTH-1:0]   rs_alu_a_out,
   output logic [ROB_WIDTH-1:0]  rs_alu_dest_out,
   output logic [ADDR_WIDTH-1:0] rs_alu_pc_out,
   output logic [OP_WIDTH-1:0]   rs_alu_opcode_out
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]    busy_q;
   logic [OP_WIDTH-1:0]   op_q   [RS_SIZE];
   logic [ID_WIDTH-1:0]   vj_q   [RS_SIZE];
   logic [ID_WIDTH-1:0]   vk_q   [RS_SIZE];
   logic [ID_WIDTH-1:0]   a_q    [RS_SIZE];
   logic [ROB_WIDTH-1:0]  qj_q   [RS_SIZE];
   logic [ROB_WIDTH-1:0]  qk_q   [RS_SIZE];
   logic [ROB_WIDTH-1:0]  dest_q [RS_SIZE];
   logic [ADDR_WIDTH-1:0] pc_q   [RS_SIZE];

   logic                  alu_en_q;
   logic [ID_WIDTH-1:0]   alu_vj_q, alu_vk_q, alu_a_q;
   logic [ROB_WIDTH-1:0]  alu_dest_q;
   logic [ADDR_WIDTH-1:0] alu_pc_q;
   logic [OP_WIDTH-1:0]   alu_op_q;

   logic                  free_found, rdy_found;
   logic [IDX_W-1:0]      free_idx, rdy_idx;
   logic [ID_WIDTH-1:0]   disp_vj_d, disp_vk_d;
   logic [ROB_WIDTH-1:0]  disp_qj_d, disp_qk_d;

   // Tag 0 never names a producer, so it can never match a broadcast.
   function automatic logic tag_hit(input logic [ROB_WIDTH-1:0] q,
                                    input logic en,
                                    input logic [ROB_WIDTH-1:0] tag);
      return en && (q != '0) && (q == tag);
   endfunction

   // Descending scan so the lowest index is the one left standing.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      rdy_found  = 1'b0;
      rdy_idx    = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
            rdy_found = 1'b1;
            rdy_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      disp_vj_d = dispatcher_rs_vj_in;
      disp_qj_d = dispatcher_rs_qj_in;
      disp_vk_d = dispatcher_rs_vk_in;
      disp_qk_d = dispatcher_rs_qk_in;
      if (tag_hit(dispatcher_rs_qj_in, alu_cdb_en_in, alu_cdb_tag_in)) begin
         disp_vj_d = alu_cdb_value_in;
         disp_qj_d = '0;
      end else if (tag_hit(dispatcher_rs_qj_in, lsb_cdb_en_in, lsb_cdb_tag_in)) begin
         disp_vj_d = lsb_cdb_value_in;
         disp_qj_d = '0;
      end
      if (tag_hit(dispatcher_rs_qk_in, alu_cdb_en_in, alu_cdb_tag_in)) begin
         disp_vk_d = alu_cdb_value_in;
         disp_qk_d = '0;
      end else if (tag_hit(dispatcher_rs_qk_in, lsb_cdb_en_in, lsb_cdb_tag_in)) begin
         disp_vk_d = lsb_cdb_value_in;
         disp_qk_d = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || rob_rs_clear_in) begin
         busy_q     <= '0;
         alu_en_q   <= 1'b0;
         alu_vj_q   <= '0;
         alu_vk_q   <= '0;
         alu_a_q    <= '0;
         alu_dest_q <= '0;
         alu_pc_q   <= '0;
         alu_op_q   <= '0;
      end else if (!rdy_in) begin
         alu_en_q <= 1'b0;
      end else begin
         assert (!(dispatcher_rs_en_in && !free_found));
         alu_en_q <= 1'b0;
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
               if (tag_hit(qj_q[i], alu_cdb_en_in, alu_cdb_tag_in)) begin
                  vj_q[i] <= alu_cdb_value_in;
                  qj_q[i] <= '0;
               end else if (tag_hit(qj_q[i], lsb_cdb_en_in, lsb_cdb_tag_in)) begin
                  vj_q[i] <= lsb_cdb_value_in;
                  qj_q[i] <= '0;
               end
               if (tag_hit(qk_q[i], alu_cdb_en_in, alu_cdb_tag_in)) begin
                  vk_q[i] <= alu_cdb_value_in;
                  qk_q[i] <= '0;
               end else if (tag_hit(qk_q[i], lsb_cdb_en_in, lsb_cdb_tag_in)) begin
                  vk_q[i] <= lsb_cdb_value_in;
                  qk_q[i] <= '0;
               end
            end
         end
         if (rdy_found) begin
            busy_q[rdy_idx] <= 1'b0;
            alu_en_q        <= 1'b1;
            alu_vj_q        <= vj_q[rdy_idx];
            alu_vk_q        <= vk_q[rdy_idx];
            alu_a_q         <= a_q[rdy_idx];
            alu_dest_q      <= dest_q[rdy_idx];
            alu_pc_q        <= pc_q[rdy_idx];
            alu_op_q        <= op_q[rdy_idx];
         end
         // The dispatch slot was free before this edge, so it never collides
         // with the issuing slot or with any entry being woken.
         if (dispatcher_rs_en_in && free_found) begin
            busy_q[free_idx] <= 1'b1;
            op_q[free_idx]   <= dispatcher_rs_opcode_in;
            vj_q[free_idx]   <= disp_vj_d;
            qj_q[free_idx]   <= disp_qj_d;
            vk_q[free_idx]   <= disp_vk_d;
            qk_q[free_idx]   <= disp_qk_d;
            a_q[free_idx]    <= dispatcher_rs_a_in;
            pc_q[free_idx]   <= dispatcher_rs_pc_in;
            dest_q[free_idx] <= dispatcher_rs_dest_in;
         end
      end
   end

   assign rs_full_out       = &busy_q;
   assign rs_alu_en_out     = alu_en_q;
   assign rs_alu_vj_out     = alu_vj_q;
   assign rs_alu_vk_out     = alu_vk_q;
   assign rs_alu_a_out      = alu_a_q;
   assign rs_alu_dest_out   = alu_dest_q;
   assign rs_alu_pc_out     = alu_pc_q;
   assign rs_alu_opcode_out = alu_op_q;

endmodule

`default_nettype wire
